sim_run_monitor: RTL

//  End-of-test controller sitting beside the core in simulation top level. Receives retire and

---
 rtl/sim_run_monitor.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sim_run_monitor.sv
// ----------------------------------------------------------------------------
// sim_run_monitor
//   End-of-test controller for the simulation top level. Watches core retire
//   and halt events and ends the run by clean halt (via a short drain),
//   watchdog (no retires for too long) or hard timeout.
//
// Ports
//   clk            in   core clock
//   reset          in   asynchronous active-low reset (0 = in reset)
//   retire_vld     in   one instruction retired this cycle
//   halt_req       in   core requests end of test
//   halt_pass      in   test verdict, valid with halt_req
//   cycle_count    out  cycles counted in RUN/DRAIN (saturating)
//   retired_count  out  retires counted in RUN/DRAIN (saturating)
//   done           out  run finished
//   pass           out  run passed (meaningful when done)
//   fail_code      out  0 NONE, 1 HALT, 2 WDOG, 3 TIMEOUT
//   finish_req     out  one-cycle pulse on the first cycle in DONE
// ----------------------------------------------------------------------------
module sim_run_monitor #(
    parameter int unsigned MAX_CYCLES   = 100,
    parameter int unsigned WDOG_CYCLES  = 32,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_vld,
    input  logic             halt_req,
    input  logic             halt_pass,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic             finish_req
);

    // One spare bit so the watchdog can step past its trip value on a halt edge.
    localparam int unsigned WDOG_W  = $clog2(WDOG_CYCLES + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_HALT    = 2'd1;
    localparam logic [1:0] CODE_WDOG    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [1:0]         code_q, code_d;
    logic               finish_q, finish_d;

    // Next-state and status logic.
    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        retired_d = retired_q;
        wdog_d    = wdog_q;
        drain_d   = drain_q;
        done_d    = done_q;
        pass_d    = pass_q;
        code_d    = code_q;
        finish_d  = 1'b0;

        // Counters advance in RUN and DRAIN, including the edge into DONE.
        if (state_q != ST_DONE) begin
            if (cycle_q != {CNT_W{1'b1}}) begin
                cycle_d = cycle_q + CNT_W'(1);
            end
            if (retire_vld && (retired_q != {CNT_W{1'b1}})) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_RUN: begin
                wdog_d = retire_vld ? '0 : wdog_q + WDOG_W'(1);
                // Exit priority: halt, then watchdog, then timeout.
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    pass_d  = halt_pass;
                    code_d  = CODE_HALT;
                    drain_d = '0;
                end else if (!retire_vld && (wdog_q == WDOG_W'(WDOG_CYCLES - 1))) begin
                    state_d  = ST_DONE;
                    code_d   = CODE_WDOG;
                    pass_d   = 1'b0;
                    done_d   = 1'b1;
                    finish_d = 1'b1;
                end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d  = ST_DONE;
                    code_d   = CODE_TIMEOUT;
                    pass_d   = 1'b0;
                    done_d   = 1'b1;
                    finish_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    finish_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            cycle_q   <= '0;
            retired_q <= '0;
            wdog_q    <= '0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            code_q    <= CODE_NONE;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            wdog_q    <= wdog_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            code_q    <= code_d;
            finish_q  <= finish_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_code     = code_q;
    assign finish_req    = finish_q;

`ifndef SYNTHESIS
    // End-of-run report, printed with the values settled after the DONE entry edge.
    always @(posedge finish_q) begin
        $strobe("sim_run_monitor: run ended code=%0d cycles=%0d retired=%0d",
                code_q, cycle_q, retired_q);
    end
`endif

endmodule
